// File: rtl/l2_bus_responder_pkg.sv
// Shared bus parameters, message codes and line/beat helpers for the L2 bus responder.
// Imported by the responder, its interface and the testbench.
package l2_bus_responder_pkg;

  localparam int CACHE_OFFSET_BITS = 3;
  localparam int BUS_OFFSET_BITS   = 1;
  localparam int DATA_WIDTH        = 32;
  localparam int ADDRESS_WIDTH     = 32;
  localparam int MSG_BITS          = 4;

  localparam int CACHE_WORDS = 1 << CACHE_OFFSET_BITS;
  localparam int BUS_WORDS   = 1 << BUS_OFFSET_BITS;
  localparam int CACHE_WIDTH = DATA_WIDTH * CACHE_WORDS;
  localparam int BUS_WIDTH   = DATA_WIDTH * BUS_WORDS;
  // One extra bit so the counter can hold the beat count itself without wrapping.
  localparam int BEAT_CNT_W  = CACHE_OFFSET_BITS - BUS_OFFSET_BITS + 1;

  typedef logic [MSG_BITS-1:0]      msg_t;
  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [BUS_WIDTH-1:0]     bus_t;
  typedef logic [CACHE_WIDTH-1:0]   line_t;
  typedef logic [BEAT_CNT_W-1:0]    cnt_t;

  localparam msg_t NO_REQ        = 4'd0;
  localparam msg_t R_REQ         = 4'd1;
  localparam msg_t RFO_BCAST     = 4'd2;
  localparam msg_t WB_REQ        = 4'd3;
  localparam msg_t INVLD         = 4'd4;
  localparam msg_t WS_BCAST      = 4'd5;
  localparam msg_t FLUSH         = 4'd6;
  localparam msg_t FLUSH_S       = 4'd7;
  localparam msg_t C_WB          = 4'd8;
  localparam msg_t C_FLUSH_BCAST = 4'd9;
  localparam msg_t EN_ACCESS     = 4'd10;
  localparam msg_t HOLD_BUS      = 4'd11;
  localparam msg_t MEM_RESP      = 4'd12;
  localparam msg_t MEM_RESP_S    = 4'd13;
  localparam msg_t REQ_FLUSH     = 4'd14;

  function automatic bus_t get_beat(line_t line, cnt_t idx);
    bus_t beat;
    beat = '0;
    for (int b = 0; b < CACHE_WIDTH / BUS_WIDTH; b++) begin
      if (idx == cnt_t'(b)) beat = line[b*BUS_WIDTH +: BUS_WIDTH];
    end
    return beat;
  endfunction

  function automatic line_t put_beat(line_t line, cnt_t idx, bus_t beat);
    line_t result;
    result = line;
    for (int b = 0; b < CACHE_WIDTH / BUS_WIDTH; b++) begin
      if (idx == cnt_t'(b)) result[b*BUS_WIDTH +: BUS_WIDTH] = beat;
    end
    return result;
  endfunction

endpackage

// File: rtl/l2_bus_responder_if.sv
// Bus-side and backing-memory-side signals of the L2 bus responder.
// The slave modport is the responder; the master modport is everything around it.
interface l2_bus_responder_if;
  import l2_bus_responder_pkg::*;

  msg_t  bus_msg_in;
  addr_t bus_address_in;
  bus_t  bus_data_in;
  logic  bus_master;
  logic  bus_shared;
  msg_t  bus_msg_out;
  addr_t bus_address_out;
  bus_t  bus_data_out;
  logic  req_ready;

  logic  mem_req;
  logic  mem_we;
  addr_t mem_address;
  line_t mem_wdata;
  logic  mem_ack;
  line_t mem_rdata;

  modport slave (
    input  bus_msg_in, bus_address_in, bus_data_in, bus_master, bus_shared,
    output bus_msg_out, bus_address_out, bus_data_out, req_ready,
    output mem_req, mem_we, mem_address, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output bus_msg_in, bus_address_in, bus_data_in, bus_master, bus_shared,
    input  bus_msg_out, bus_address_out, bus_data_out, req_ready,
    input  mem_req, mem_we, mem_address, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/l2_bus_responder.sv
// Memory-side responder of the shared L1 bus: gathers write-back beats into a line,
// does one line access on the backing memory and streams read lines back as beats.
module l2_bus_responder
  import l2_bus_responder_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  l2_bus_responder_if.slave  bus_io
);

  localparam int   BEATS     = CACHE_WORDS / BUS_WORDS;
  localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_RECEIVE,
    WB_MEM,
    WB_RESP,
    RD_MEM,
    RD_TRANSFER
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  addr_t  addr_q, addr_d;
  line_t  line_q, line_d;
  logic   shared_q, shared_d;

  msg_t   msg_out_q, msg_out_d;
  addr_t  addr_out_q, addr_out_d;
  bus_t   data_out_q, data_out_d;
  logic   ready_q, ready_d;
  logic   mem_req_q, mem_req_d;
  logic   mem_we_q, mem_we_d;
  addr_t  mem_addr_q, mem_addr_d;
  line_t  mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    line_d   = line_q;
    shared_d = shared_q;

    unique case (state_q)
      IDLE: begin
        if (bus_io.bus_master) begin
          if (bus_io.bus_msg_in == WB_REQ) begin
            addr_d  = bus_io.bus_address_in;
            cnt_d   = '0;
            state_d = WB_RECEIVE;
          end else if (bus_io.bus_msg_in == R_REQ) begin
            addr_d  = bus_io.bus_address_in;
            state_d = RD_MEM;
          end
        end
      end

      WB_RECEIVE: begin
        if (bus_io.bus_master) begin
          line_d = put_beat(line_q, cnt_q, bus_io.bus_data_in);
          cnt_d  = cnt_q + cnt_t'(1);
          if (cnt_q == LAST_BEAT) state_d = WB_MEM;
        end
      end

      WB_MEM: begin
        if (bus_io.mem_ack) state_d = WB_RESP;
      end

      WB_RESP: state_d = IDLE;

      RD_MEM: begin
        if (bus_io.mem_ack) begin
          line_d   = bus_io.mem_rdata;
          shared_d = bus_io.bus_shared;
          cnt_d    = '0;
          state_d  = RD_TRANSFER;
        end
      end

      RD_TRANSFER: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LAST_BEAT) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet appear
  // on the very edge that enters the state they belong to.
  always_comb begin
    msg_out_d   = NO_REQ;
    addr_out_d  = '0;
    data_out_d  = '0;
    ready_d     = (state_d != IDLE);
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_d)
      WB_MEM: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = line_d;
      end
      WB_RESP: begin
        msg_out_d  = MEM_RESP;
        addr_out_d = addr_d;
      end
      RD_MEM: begin
        mem_req_d  = 1'b1;
        mem_addr_d = addr_d;
      end
      RD_TRANSFER: begin
        msg_out_d  = shared_d ? MEM_RESP_S : MEM_RESP;
        addr_out_d = addr_d;
        data_out_d = get_beat(line_d, cnt_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      shared_q    <= 1'b0;
      msg_out_q   <= NO_REQ;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
      shared_q    <= shared_d;
      msg_out_q   <= msg_out_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus_io.bus_msg_out     = msg_out_q;
  assign bus_io.bus_address_out = addr_out_q;
  assign bus_io.bus_data_out    = data_out_q;
  assign bus_io.req_ready       = ready_q;
  assign bus_io.mem_req         = mem_req_q;
  assign bus_io.mem_we          = mem_we_q;
  assign bus_io.mem_address     = mem_addr_q;
  assign bus_io.mem_wdata       = mem_wdata_q;

endmodule
